arbitro_wrr: RTL
================

# arbitro_wrr

Four-class weighted round-robin arbiter of the QoS PCIe path. It sits directly downstream of the four class FIFOs, which hold 12-bit words. It pops those FIFOs according to per-class weights and merges the popped words into a single 12-bit output stream. It stops issuing pops while the downstream stage signals almost-full.

## Interface
Parameters:
- `DATA_W`, 12: word width.
- `WGT_W`, 3: width of each weight and of each credit counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `init`  in  1: while high, the weights are sampled and loaded.
- `weight0..weight3`  in  `WGT_W`: number of pops per turn for class k.
- `empty0..empty3`  in  1: empty flag of class FIFO k (registered in the FIFO).
- `fifo_dataout0..3`  in  `DATA_W`: FIFO k read data, valid the cycle after `popk`.
- `almost_full`  in  1: downstream backpressure.
- `pop0..pop3`  out  1: read strobe to FIFO k; combinational from registered state.
- `data_out`  out  `DATA_W`: merged word, registered.
- `valid_out`  out  1: `data_out` valid, registered.
- `idle_out`  out  1: high in IDLE with nothing in flight.

## Operation
- FSM states: RESET, INIT, IDLE, ACTIVE.
- RESET is held while `reset`=0. After release, the next state is INIT if `init`=1, otherwise IDLE.
- INIT:
  - Each cycle, latch `weightk` into `wgt_r[k]`; a weight of 0 is stored as 1.
  - Clear all credits and set grant pointer `g`=0.
  - Exit to IDLE when `init`=0.
- IDLE:
  - Go to ACTIVE when any `emptyk`=0.
  - `init`=1 from IDLE or ACTIVE returns to INIT; any in-flight word still completes on `data_out`.
- ACTIVE grant rule, evaluated each cycle:
  - Pop class g when `almost_full`=0, `empty[g]`=0 and `credit[g]`>0; then `credit[g]` decrements.
  - The pointer moves when `credit[g]`=0, or `empty[g]`=1, or the pop just issued drops `credit[g]` to 0. The new g is the first non-empty class in order g+1, g+2, g+3, g (mod 4), and its credit is loaded from `wgt_r`.
  - A pointer move is registered; the first pop on the new class can occur in the same cycle only if its credit is already nonzero.
- At most one `popk` is high per cycle.
- If all four FIFOs are empty and nothing is in flight, go to IDLE. Credits are kept.
- `almost_full`=1 blocks new pops only. Up to 2 in-flight words still emerge; downstream thresholds account for this.
- Popping an empty FIFO is forbidden. `empty` is registered in the FIFO and already reflects the previous cycle's pop.

## Timing
- Reset values: `popk`=0, `data_out`=0, `valid_out`=0, `idle_out`=0, credits=0, `wgt_r`=1, `g`=0.
- Latency:
  - `popk` high in cycle N.
  - `fifo_dataoutk` valid in cycle N+1.
  - `data_out`/`valid_out` high in cycle N+2.
- A 2-stage in-flight tracker (valid bit + 2-bit class index) selects the mux source.
- Throughput is one word per cycle while the granted class has credit and is non-empty. Each pointer move after credit exhaustion costs 0 cycles, because the reload happens in the cycle of the last pop.
- `valid_out` is 0 in every cycle with no word arriving; there is no hold or handshake on the output.
- Reset mid-stream: in-flight words are discarded, and outputs go to their reset values immediately (asynchronously).

## Structure
- Shared QoS package holds:
  - the state encoding (RESET, INIT, IDLE, ACTIVE; 2 bits);
  - `NUM_CLASSES`=4;
  - `DATA_W`;
  - the helper that computes the next non-empty class.
- One sub-module: `sel_rr` (combinational). It takes g and the empty vector and returns the next grant index and a found flag.
- Credit counters, the in-flight tracker and the output register live in the top module.

## Test plan
1. Reset held 3 cycles, then released with `init`=1 for 2 cycles and weights 2,1,1,1. All outputs stay at reset values; `idle_out`=1 after INIT.
2. All four FIFOs preloaded with 4 words each, weights 2,1,1,1. `data_out` class order is 0,0,1,2,3,0,0,1,2,3,… with `valid_out` high continuously, starting 2 cycles after the first pop.
3. Only FIFO 2 non-empty, holding 'h37D,'hF04,'hE95. Output is those three words in order on back-to-back cycles; `pop0/1/3` never assert; then the block returns to IDLE with `idle_out`=1.
4. `almost_full` raised mid-stream. Pops stop in the same cycle, exactly 2 further `valid_out` pulses occur, and flow resumes one cycle after `almost_full` falls with no word lost or duplicated.
5. Weight 0 on class 1 with all FIFOs full. Class 1 is served exactly 1 word per turn.
6. `reset` dropped while words are in flight. `valid_out` goes 0 at once; after release with FIFOs refilled, the order restarts at class 0.

Source files
------------

// File: rtl/arbitro_wrr_pkg.sv
// Shared QoS definitions for the four-class weighted round-robin arbiter.
// State encoding, class count, word width and next-class search.
package arbitro_wrr_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int DATA_W      = 12;
    localparam int WGT_W       = 3;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } sel_t;

    // Search g+1, g+2, g+3, g; the nearest non-empty class wins.
    function automatic sel_t next_class(
        input logic [1:0]             g,
        input logic [NUM_CLASSES-1:0] empty
    );
        sel_t       r;
        logic [1:0] k;
        r = '0;
        for (int i = NUM_CLASSES; i >= 1; i--) begin
            k = g + 2'(i);
            if (!empty[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arbitro_wrr_if.sv
// FIFO-side and downstream-side signal bundle of the WRR arbiter.
// master = arbiter, slave = class FIFOs plus downstream stage.
interface arbitro_wrr_if #(
    parameter int DATA_W = 12,
    parameter int WGT_W  = 3
) ();

    logic              init;
    logic [WGT_W-1:0]  weight0;
    logic [WGT_W-1:0]  weight1;
    logic [WGT_W-1:0]  weight2;
    logic [WGT_W-1:0]  weight3;
    logic              empty0;
    logic              empty1;
    logic              empty2;
    logic              empty3;
    logic [DATA_W-1:0] fifo_dataout0;
    logic [DATA_W-1:0] fifo_dataout1;
    logic [DATA_W-1:0] fifo_dataout2;
    logic [DATA_W-1:0] fifo_dataout3;
    logic              almost_full;
    logic              pop0;
    logic              pop1;
    logic              pop2;
    logic              pop3;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              idle_out;

    modport master (
        input  init, weight0, weight1, weight2, weight3,
        input  empty0, empty1, empty2, empty3,
        input  fifo_dataout0, fifo_dataout1,
        input  fifo_dataout2, fifo_dataout3,
        input  almost_full,
        output pop0, pop1, pop2, pop3,
        output data_out, valid_out, idle_out
    );

    modport slave (
        output init, weight0, weight1, weight2, weight3,
        output empty0, empty1, empty2, empty3,
        output fifo_dataout0, fifo_dataout1,
        output fifo_dataout2, fifo_dataout3,
        output almost_full,
        input  pop0, pop1, pop2, pop3,
        input  data_out, valid_out, idle_out
    );

endinterface

// File: rtl/arbitro_wrr_sel_rr.sv
// Combinational round-robin selector: next non-empty class after g.
// found=0 when every class FIFO is empty.
module sel_rr
    import arbitro_wrr_pkg::*;
(
    input  logic [1:0]             g,
    input  logic [NUM_CLASSES-1:0] empty,
    output logic [1:0]             nxt,
    output logic                   found
);

    sel_t s;

    assign s     = next_class(g, empty);
    assign nxt   = s.idx;
    assign found = s.found;

endmodule

// File: rtl/arbitro_wrr.sv
// Four-class weighted round-robin arbiter merging class FIFOs
// into one registered output stream with a two-stage read pipe.
module arbitro_wrr #(
    parameter int DATA_W = arbitro_wrr_pkg::DATA_W,
    parameter int WGT_W  = arbitro_wrr_pkg::WGT_W
) (
    input logic           clk,
    input logic           reset,
    arbitro_wrr_if.master bus
);

    import arbitro_wrr_pkg::*;

    localparam int NC = NUM_CLASSES;

    state_t            st;
    state_t            st_nx;
    logic [WGT_W-1:0]  wgt_r  [NC];
    logic [WGT_W-1:0]  cred   [NC];
    logic [WGT_W-1:0]  wgt_in [NC];
    logic [DATA_W-1:0] din    [NC];
    logic [NC-1:0]     empty;
    logic [1:0]        g;
    logic [1:0]        nxt;
    logic [1:0]        c1;
    logic              found;
    logic              granted;
    logic              move;
    logic              all_empty;
    logic              v1;
    logic              vo_r;
    logic [DATA_W-1:0] do_r;

    assign empty = {bus.empty3, bus.empty2,
                    bus.empty1, bus.empty0};
    assign all_empty = &empty;

    assign wgt_in[0] = bus.weight0;
    assign wgt_in[1] = bus.weight1;
    assign wgt_in[2] = bus.weight2;
    assign wgt_in[3] = bus.weight3;
    assign din[0]    = bus.fifo_dataout0;
    assign din[1]    = bus.fifo_dataout1;
    assign din[2]    = bus.fifo_dataout2;
    assign din[3]    = bus.fifo_dataout3;

    sel_rr u_sel (
        .g     (g),
        .empty (empty),
        .nxt   (nxt),
        .found (found)
    );

    // Pointer advances in the cycle of the last pop, so no bubble.
    always_comb begin
        granted = 1'b0;
        move    = 1'b0;
        if (st == ST_ACTIVE) begin
            granted = !bus.almost_full && !empty[g]
                      && (cred[g] != '0);
            move    = (cred[g] == '0) || empty[g]
                      || (granted && cred[g] == WGT_W'(1));
        end
    end

    assign bus.pop0 = granted && (g == 2'd0);
    assign bus.pop1 = granted && (g == 2'd1);
    assign bus.pop2 = granted && (g == 2'd2);
    assign bus.pop3 = granted && (g == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= ST_RESET;
        else        st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            ST_RESET:  st_nx = bus.init ? ST_INIT : ST_IDLE;
            ST_INIT:   if (!bus.init) st_nx = ST_IDLE;
            ST_IDLE: begin
                if (bus.init)        st_nx = ST_INIT;
                else if (!all_empty) st_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bus.init)             st_nx = ST_INIT;
                else if (all_empty && !v1) st_nx = ST_IDLE;
            end
            default:   st_nx = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g <= 2'd0;
            for (int k = 0; k < NC; k++) begin
                wgt_r[k] <= WGT_W'(1);
                cred[k]  <= '0;
            end
        end else begin
            unique case (st)
                ST_INIT: begin
                    g <= 2'd0;
                    for (int k = 0; k < NC; k++) begin
                        wgt_r[k] <= (wgt_in[k] == '0)
                                    ? WGT_W'(1) : wgt_in[k];
                        cred[k]  <= '0;
                    end
                end
                ST_IDLE: begin
                    // Fresh turn for the current pointer on wake-up.
                    if (!bus.init && !all_empty && cred[g] == '0)
                        cred[g] <= wgt_r[g];
                end
                ST_ACTIVE: begin
                    if (granted) cred[g] <= cred[g] - WGT_W'(1);
                    if (move && found) begin
                        g         <= nxt;
                        cred[nxt] <= wgt_r[nxt];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1   <= 1'b0;
            c1   <= 2'd0;
            vo_r <= 1'b0;
            do_r <= '0;
        end else begin
            v1   <= granted;
            vo_r <= v1;
            if (granted) c1   <= g;
            if (v1)      do_r <= din[c1];
        end
    end

    assign bus.data_out  = do_r;
    assign bus.valid_out = vo_r;
    assign bus.idle_out  = (st == ST_IDLE) && !v1 && !vo_r;

endmodule
